// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if
//   Handshake and strobe bundle between the rv32i multi-cycle sequencer and
//   the datapath/memories around it.
//
//   opcode        ir[6:0] from the instruction register
//   branch_taken  ALU compare result
//   imem_ready    instruction memory has data for the current request
//   dmem_ready    data memory completed the current request
//   imem_req      instruction fetch request
//   ir_we         latch instruction register
//   dmem_req      data memory request
//   dmem_we       data memory write (store), only with dmem_req
//   rf_we         register-file write strobe
//   pc_we         PC update strobe (marks a retiring instruction)
//   pc_src        0 = pc+4, 1 = ALU target, meaningful only with pc_we
//
//   master: the sequencer side; slave: the datapath/memory side.
interface cpu_sequencer_if;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       imem_ready;
  logic       dmem_ready;
  logic       imem_req;
  logic       ir_we;
  logic       dmem_req;
  logic       dmem_we;
  logic       rf_we;
  logic       pc_we;
  logic       pc_src;

  modport master (
    input  opcode, branch_taken, imem_ready, dmem_ready,
    output imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_src
  );

  modport slave (
    output opcode, branch_taken, imem_ready, dmem_ready,
    input  imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_src
  );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Multi-cycle control FSM for the rv32i core. Walks one instruction at a
//   time through FETCH, DECODE, EXECUTE, MEM and WB, and owns the sticky
//   trap state (illegal opcode, imem timeout, dmem timeout) for the core.
//
//   Parameters
//     TIMEOUT     cycles a memory request may wait for ready (2..255)
//   Ports
//     clk         core clock, rising edge
//     rst         synchronous active-high reset
//     bus         cpu_sequencer_if.master (handshakes and strobes)
//     state       current state code (FETCH=0 .. TRAP=5)
//     trap        sticky fault indicator
//     trap_cause  0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout
//     instret     retired-instruction count
//
//   Optional feature macro: SEQ_INSTRET_EN. When defined, instret is a
//   wrapping 32-bit counter of retire cycles; otherwise it is tied to 0.
module cpu_sequencer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  cpu_sequencer_if.master        bus,
  output logic [2:0]             state,
  output logic                   trap,
  output logic [1:0]             trap_cause,
  output logic [31:0]            instret
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_ALU    = 3'd0,
    C_LOAD   = 3'd1,
    C_STORE  = 3'd2,
    C_BRANCH = 3'd3,
    C_JUMP   = 3'd4
  } iclass_e;

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  state_e      state_q, state_d;
  iclass_e     iclass_q, iclass_d;
  logic [7:0]  wait_q, wait_d;
  logic        trap_q, trap_d;
  logic [1:0]  cause_q, cause_d;

  // State register: all control flops, cleared synchronously by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      iclass_q <= C_ALU;
      wait_q   <= '0;
      trap_q   <= 1'b0;
      cause_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      iclass_q <= iclass_d;
      wait_q   <= wait_d;
      trap_q   <= trap_d;
      cause_q  <= cause_d;
    end
  end

  // Next-state logic. The wait counter only advances while FETCH/MEM stall;
  // any state change clears it, so it always starts at 0 on entry. Ready on
  // the same cycle the count hits TIMEOUT is checked first and wins.
  always_comb begin
    state_d  = state_q;
    iclass_d = iclass_q;
    wait_d   = wait_q;
    trap_d   = trap_q;
    cause_d  = cause_q;
    case (state_q)
      S_FETCH: begin
        if (bus.imem_ready) begin
          state_d = S_DECODE;
        end else if (wait_q == TIMEOUT_CNT) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'd2;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
        case (bus.opcode)
          7'b0110011, 7'b0010011,
          7'b0110111, 7'b0010111: iclass_d = C_ALU;
          7'b0000011:             iclass_d = C_LOAD;
          7'b0100011:             iclass_d = C_STORE;
          7'b1100011:             iclass_d = C_BRANCH;
          7'b1101111, 7'b1100111: iclass_d = C_JUMP;
          default: begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
            cause_d = 2'd1;
          end
        endcase
      end
      S_EXECUTE: begin
        case (iclass_q)
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BRANCH:        state_d = S_FETCH;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ready) begin
          state_d = (iclass_q == C_STORE) ? S_FETCH : S_WB;
        end else if (wait_q == TIMEOUT_CNT) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'd3;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB:   state_d = S_FETCH;
      S_TRAP: state_d = S_TRAP;
      default: begin
        // Unused codes 6/7 are treated as a corrupted opcode path.
        state_d = S_TRAP;
        trap_d  = 1'b1;
        cause_d = 2'd1;
      end
    endcase
    if (state_d != state_q) wait_d = '0;
  end

  // Output decode. Everything is forced low while rst is high, and TRAP
  // falls into the default branch so no strobe can fire there.
  always_comb begin
    bus.imem_req = 1'b0;
    bus.ir_we    = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    bus.rf_we    = 1'b0;
    bus.pc_we    = 1'b0;
    bus.pc_src   = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          bus.imem_req = 1'b1;
          bus.ir_we    = bus.imem_ready;
        end
        S_EXECUTE: begin
          if (iclass_q == C_BRANCH) begin
            bus.pc_we  = 1'b1;
            bus.pc_src = bus.branch_taken;
          end
        end
        S_MEM: begin
          bus.dmem_req = 1'b1;
          bus.dmem_we  = (iclass_q == C_STORE);
          bus.pc_we    = bus.dmem_ready && (iclass_q == C_STORE);
        end
        S_WB: begin
          bus.rf_we  = 1'b1;
          bus.pc_we  = 1'b1;
          bus.pc_src = (iclass_q == C_JUMP);
        end
        default: ;
      endcase
    end
  end

  assign state      = rst ? 3'd0 : state_q;
  assign trap       = trap_q & ~rst;
  assign trap_cause = rst ? 2'd0 : cause_q;

`ifdef SEQ_INSTRET_EN
  logic [31:0] instret_q, instret_d;

  // Retire counter: pc_we marks the retire cycle and is never high in TRAP.
  always_comb begin
    instret_d = instret_q;
    if (bus.pc_we) instret_d = instret_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) instret_q <= '0;
    else     instret_q <= instret_d;
  end

  assign instret = rst ? 32'd0 : instret_q;
`else
  assign instret = 32'd0;
`endif

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control FSM for the rv32i core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback, driving the enables of the PC, instruction register, ALU operand path, data-memory port and register-file write port. It sits in `top` beside `regfile_inst`, consumes the opcode from the instruction register plus memory handshakes, and owns the trap/timeout condition for the whole core.

## Interface
- `TIMEOUT`, 16: max cycles a memory request may wait for ready before trapping; legal range 2..255.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  7  `ir[6:0]`; valid from the cycle after `ir_we`.
- `branch_taken`  in  1  ALU compare result; sampled in EXECUTE.
- `imem_ready`  in  1  instruction memory has data for the current request.
- `dmem_ready`  in  1  data memory completed the current request.
- `imem_req`  out  1  instruction fetch request.
- `ir_we`  out  1  latch instruction register.
- `dmem_req`  out  1  data memory request.
- `dmem_we`  out  1  data memory write (store); only with `dmem_req`.
- `rf_we`  out  1  register-file write strobe.
- `pc_we`  out  1  PC update strobe.
- `pc_src`  out  1  0 = pc+4, 1 = ALU target (jump / taken branch); meaningful only with `pc_we`.
- `state`  out  3  current state encoding, for debug and the testbench.
- `trap`  out  1  sticky fault indicator.
- `trap_cause`  out  2  0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout.
- `instret`  out  32  retired-instruction count (see Configuration).

## Operation
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5; codes 6–7 go to TRAP with cause 1.
- FETCH: `imem_req`=1. On `imem_ready`, assert `ir_we` in the same cycle and go to DECODE. Otherwise stay.
- DECODE: classify `opcode` into a registered class. Legal opcodes are 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111 and 0010111. Any other opcode, including SYSTEM and FENCE, goes to TRAP with cause 1. Legal opcodes go to EXECUTE.
- EXECUTE (1 cycle):
  - LOAD/STORE go to MEM.
  - BRANCH asserts `pc_we` and retires to FETCH, with `pc_src`=`branch_taken`.
  - All other classes go to WB.
- MEM: `dmem_req`=1, with `dmem_we`=1 for STORE. On `dmem_ready`:
  - STORE asserts `pc_we` (`pc_src`=0), retires and goes to FETCH.
  - LOAD goes to WB.
- WB: assert `rf_we` and `pc_we` in the same cycle, then retire and go to FETCH.
  - `pc_src`=1 for JAL/JALR, else 0.
  - An rd=x0 write is harmless because the regfile ignores it.
- Retire: the cycle in which `pc_we` is asserted.
- Wait counter (8 bit):
  - Clears on entry to FETCH or MEM.
  - Increments each cycle that state stays FETCH/MEM without ready.
  - When it reaches `TIMEOUT` with ready still low, the next state is TRAP with cause 2 (FETCH) or 3 (MEM).
  - Ready arriving in the same cycle the count reaches `TIMEOUT` wins; no trap.
- TRAP:
  - All strobes 0, `trap`=1.
  - `trap_cause` is held.
  - The state holds until `rst`.
- All strobes are decoded from state plus ready inputs only. No strobe is ever asserted in TRAP or while `rst`=1.

## Timing
- Reset: with `rst` high at an edge, the next state is FETCH, the wait counter is 0, `trap`=0, `trap_cause`=0 and `instret`=0. All outputs read 0 while `rst`=1, including `imem_req`.
- `rst` overrides every transition, including mid-MEM and TRAP. Any outstanding memory request is abandoned; the memories must tolerate a dropped request.
- The first `imem_req` appears in the first cycle with `rst` low.
- Zero-wait memory latencies, FETCH to retire inclusive:
  - branch: 3 cycles
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles
  - store: 4 cycles
  - load: 5 cycles
- Each ready-low cycle adds 1 cycle.
- `ir_we` is a single-cycle pulse. `dmem_req`/`imem_req` stay high continuously until ready or timeout.
- Ready inputs are ignored outside their request state.

## Configuration
- `SEQ_INSTRET_EN` defined:
  - `instret` is a 32-bit counter that increments by 1 on every retire cycle.
  - It wraps 0xFFFFFFFF→0 and is not incremented in TRAP.
- Undefined: `instret` is tied to 0 and no counter flops are synthesized.

## Test plan
- Reset, then `opcode`=0010011, both readies high → state sequence 0,1,2,4,0. `pc_we`=1 and `rf_we`=1 only in the WB cycle. With the macro, `instret` becomes 1 after 4 cycles.
- Load 0000011, `dmem_ready` low for 3 cycles → `dmem_req` high for 4 cycles with `dmem_we`=0. Retire is 8 cycles after FETCH entry, with `rf_we` asserted.
- Branch 1100011, `branch_taken`=1 → `pc_we`=1 and `pc_src`=1 in the EXECUTE cycle, `rf_we` never asserted, back in FETCH on the next cycle.
- Opcode 1110011 → TRAP, `trap`=1, `trap_cause`=1. Strobes stay 0 for 20 cycles. `rst` for one cycle → state 0, `trap`=0.
- `imem_ready` held low with `TIMEOUT`=16 → TRAP with cause 2 after 17 FETCH cycles. A second run with ready rising on exactly the 17th cycle → no trap and DECODE next.
- Assert `rst` during MEM of a store → `dmem_req` drops to 0 in the reset cycle, state goes to 0, and `instret` is cleared.
